// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared operation and state encodings for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - WIDTH+1 bit add/subtract step; borrow is carry-out when adding
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             sub,
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH:0]   y,
  output logic [WIDTH:0]   sum,
  output logic             borrow
);

  logic [WIDTH+1:0] full;

  assign full   = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{(WIDTH+1){1'b0}}, sub};
  assign sum    = full[WIDTH:0];
  assign borrow = sub ? ~full[WIDTH+1] : full[WIDTH+1];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle into HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_q;
  logic [WIDTH-1:0] mcand_q;
  logic [PW-1:0]    prod_q, prod_d, prod_neg;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q, zero_q;
  logic             is_div, accept, sgn, last;
  logic [WIDTH-1:0] abs_a, abs_b, fix_hi, fix_lo;
  logic [WIDTH:0]   step_x, step_y, step_sum;
  logic             step_borrow;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign accept = (state_q == IDLE) && start && !flush;
  assign sgn    = op_is_signed(op);
  assign abs_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sgn && b[WIDTH-1]) ? -b : b;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // prod_q holds {product} for multiply and {remainder, dividend/quotient} for divide
  assign step_x = is_div ? prod_q[PW-1:WIDTH-1] : {1'b0, prod_q[PW-1:WIDTH]};
  assign step_y = {1'b0, mcand_q};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .sub    (is_div),
    .x      (step_x),
    .y      (step_y),
    .sum    (step_sum),
    .borrow (step_borrow)
  );

  always_comb begin
    prod_d = prod_q;
    if (is_div)
      prod_d = {(step_borrow ? prod_q[PW-2:WIDTH-1] : step_sum[WIDTH-1:0]),
                prod_q[WIDTH-2:0], ~step_borrow};
    else if (prod_q[0])
      prod_d = {step_sum, prod_q[WIDTH-1:1]};
    else
      prod_d = {1'b0, prod_q[PW-1:1]};
  end

  assign prod_neg = ~prod_q + PW'(1);

  // A zero divisor leaves remainder = |a|, so the sign fix alone restores hi = a
  always_comb begin
    fix_hi = prod_q[PW-1:WIDTH];
    fix_lo = prod_q[WIDTH-1:0];
    if (is_div) begin
      if (neg_rem_q) fix_hi = -prod_q[PW-1:WIDTH];
      if (zero_q)         fix_lo = '1;
      else if (neg_quo_q) fix_lo = -prod_q[WIDTH-1:0];
    end else if (neg_quo_q) begin
      fix_hi = prod_neg[PW-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (flush)     state_d = IDLE;
        else if (last) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = flush ? IDLE : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_MULT;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= muldiv_op_e'(op);
        mcand_q   <= abs_b;
        prod_q    <= {{WIDTH{1'b0}}, abs_a};
        cnt_q     <= '0;
        neg_quo_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_q <= sgn && a[WIDTH-1];
        zero_q    <= (b == '0);
      end else if (state_q == RUN) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + CW'(1);
      end else if (state_q == FIX && !flush) begin
        hi          <= fix_hi;
        lo          <= fix_lo;
        div_by_zero <= is_div && zero_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: MIPS HI/LO semantics computed with 64-bit host arithmetic
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] mh, output logic [31:0] ml, output logic mz);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    mz = 1'b0;
    mh = '0;
    ml = '0;
    case (o)
      2'b00: begin p = sx * sy; mh = p[63:32]; ml = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; mh = p[63:32]; ml = p[31:0]; end
      2'b10: begin
        if (y == 0) begin mh = x; ml = '1; mz = 1'b1; end
        else begin q = sx / sy; r = sx % sy; ml = q[31:0]; mh = r[31:0]; end
      end
      default: begin
        if (y == 0) begin mh = x; ml = '1; mz = 1'b1; end
        else begin ml = x / y; mh = x % y; end
      end
    endcase
  endtask

  task automatic wait_done(input string tag, input int from_cyc);
    int cyc;
    cyc = from_cyc;
    while (!done && cyc < W + 10) begin
      check({tag, "_busy"}, busy, (cyc <= W + 1));
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, W + 2);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    logic ez;
    model(o, x, y, eh, el, ez);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag, 1);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dbz"}, div_by_zero, ez);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    bit seen_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi_k", hi, 32'hFFFFFFFE);
    check("multu_max_lo_k", lo, 32'h00000001);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7);
    check("mult_neg_lo_k", lo, 32'hFFFFFFEB);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2);
    check("div_neg_lo_k", lo, 32'hFFFFFFFD);
    check("div_neg_hi_k", hi, 32'hFFFFFFFF);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0);
    check("divu_zero_dbz_k", div_by_zero, 1);
    check("divu_zero_hi_k", hi, 32'h64);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo_k", lo, 32'h80000000);
    check("div_ovf_hi_k", hi, 32'h0);

    // start while busy must not disturb the running MULTU
    op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    op = 2'b11; a = 32'd77; b = 32'd99; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start", 11);
    check("busy_start_hi", hi, 0);
    check("busy_start_lo", lo, 30);
    tick();

    // flush mid-run: no done, results retained
    op = 2'b11; a = 32'd9; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("flush_busy14", busy, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("flush_no_done", seen_done, 0);
    check("flush_hi", hi, 0);
    check("flush_lo", lo, 30);
    check("flush_dbz", div_by_zero, 0);

    // reset in the middle of a DIVU
    op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    run_op("after_rst", 2'b01, 32'd2, 32'd3);
    check("after_rst_lo_k", lo, 6);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFFFFFF;
        3:       rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", n), ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
